// File: rtl/pin_verifier_pkg.sv
// Shared types and constants for the PIN-entry verifier.
package pin_verifier_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    LOCK  = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_PASSKEY = 8'b10100101;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pin_verifier_hold_timer.sv
// Loadable down-counter shared by the result-hold and lockout phases.
// done is high in the cycle the loaded count has run down to zero.
module hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] r_count;
  logic         r_busy;

  // A fresh load always wins over the expiry of the previous interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_count == '0) r_busy  <= 1'b0;
      else               r_count <= r_count - 1'b1;
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_count == '0);

endmodule

// File: rtl/pin_verifier.sv
// PIN-entry verifier: collects PIN_LEN digits, compares with PASSKEY, holds the result.
// Define LOCKOUT_EN to enable lockout after MAX_TRIES consecutive failures.
module pin_verifier
  import pin_verifier_pkg::*;
#(
  parameter int                          DIGIT_W     = 2,
  parameter int                          PIN_LEN     = 4,
  parameter logic [DIGIT_W*PIN_LEN-1:0]  PASSKEY     = (DIGIT_W*PIN_LEN)'(DEFAULT_PASSKEY),
  parameter int                          HOLD_CYCLES = 50_000_000,
  parameter int                          MAX_TRIES   = 3,
  parameter int                          LOCK_CYCLES = 500_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          submit,
  input  logic                          clear,
  output logic                          waiting,
  output logic                          correct,
  output logic                          incorrect,
  output logic                          locked,
  output logic [$clog2(PIN_LEN+1)-1:0]  digits_in,
  output logic                          bug
);

  localparam int W     = DIGIT_W * PIN_LEN;
  localparam int CNT_W = $clog2(PIN_LEN + 1);
  localparam int TMAX  = maxInt(HOLD_CYCLES, LOCK_CYCLES);
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PIN_LEN - 1);

  state_t           r_state;
  logic [W-1:0]     r_shift;
  logic [CNT_W-1:0] r_digits;
  logic             r_waiting;
  logic             r_correct;
  logic             r_incorrect;
  logic             r_bug;
  logic             w_timerLoad;
  logic [TW-1:0]    w_timerVal;
  logic             w_timerBusy;
  logic             w_timerDone;
  logic             w_timerExpired;
  logic [W-1:0]     w_nextShift;

  assign w_nextShift    = (r_shift << DIGIT_W) | W'(digit);
  assign w_timerExpired = w_timerDone || !w_timerBusy;

`ifdef LOCKOUT_EN
  localparam int               FAIL_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]    LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

  logic [FAIL_W-1:0] r_failCnt;
  logic              r_locked;
  logic              w_goLock;

  assign w_goLock = (r_failCnt == FAIL_MAX);
  assign locked   = r_locked;

  // The timer is reloaded on the CHECK cycle and again at the HOLD-to-LOCK handover.
  always_comb begin
    w_timerLoad = 1'b0;
    w_timerVal  = HOLD_LOAD;
    if (r_state == CHECK) begin
      w_timerLoad = 1'b1;
    end else if (r_state == HOLD && w_timerExpired && w_goLock) begin
      w_timerLoad = 1'b1;
      w_timerVal  = LOCK_LOAD;
    end
  end
`else
  assign locked      = 1'b0;
  assign w_timerLoad = (r_state == CHECK);
  assign w_timerVal  = HOLD_LOAD;
`endif

  hold_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_timerLoad),
    .load_val (w_timerVal),
    .busy     (w_timerBusy),
    .done     (w_timerDone)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_digits    <= '0;
      r_waiting   <= 1'b1;
      r_correct   <= 1'b0;
      r_incorrect <= 1'b0;
      r_bug       <= 1'b0;
`ifdef LOCKOUT_EN
      r_failCnt   <= '0;
      r_locked    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, ENTRY: begin
          if (clear) begin
            r_shift  <= '0;
            r_digits <= '0;
            r_state  <= IDLE;
          end else if (submit) begin
            r_shift <= w_nextShift;
            if (r_digits == LAST_IDX) begin
              r_digits  <= '0;
              r_waiting <= 1'b0;
              r_state   <= CHECK;
            end else begin
              r_digits <= r_digits + 1'b1;
              r_state  <= ENTRY;
            end
          end
        end
        CHECK: begin
          if (r_shift == PASSKEY) begin
            r_correct <= 1'b1;
`ifdef LOCKOUT_EN
            r_failCnt <= '0;
`endif
          end else begin
            r_incorrect <= 1'b1;
`ifdef LOCKOUT_EN
            r_failCnt <= r_failCnt + 1'b1;
`endif
          end
          r_state <= HOLD;
        end
        HOLD: begin
          if (w_timerExpired) begin
            r_correct   <= 1'b0;
            r_incorrect <= 1'b0;
            r_shift     <= '0;
`ifdef LOCKOUT_EN
            if (w_goLock) begin
              r_locked <= 1'b1;
              r_state  <= LOCK;
            end else begin
              r_waiting <= 1'b1;
              r_state   <= IDLE;
            end
`else
            r_waiting <= 1'b1;
            r_state   <= IDLE;
`endif
          end
        end
`ifdef LOCKOUT_EN
        LOCK: begin
          if (w_timerExpired) begin
            r_locked  <= 1'b0;
            r_failCnt <= '0;
            r_waiting <= 1'b1;
            r_state   <= IDLE;
          end
        end
`endif
        default: begin
          r_bug       <= 1'b1;
          r_shift     <= '0;
          r_digits    <= '0;
          r_correct   <= 1'b0;
          r_incorrect <= 1'b0;
          r_waiting   <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign waiting   = r_waiting;
  assign correct   = r_correct;
  assign incorrect = r_incorrect;
  assign digits_in = r_digits;
  assign bug       = r_bug;

endmodule

// File: tb/tb_pin_verifier.sv
// Scoreboard bench for pin_verifier: stimulus queues expected results, a monitor checks them.
// Lockout scenario runs only when LOCKOUT_EN is defined.
module tb_pin_verifier;

  localparam int HOLD  = 4;
  localparam int LOCKC = 8;
  localparam logic [7:0] GOOD_PIN = 8'b10100101;
  localparam logic [7:0] ZERO_PIN = 8'b00000000;

  localparam int K_OK   = 0;
  localparam int K_BAD  = 1;
  localparam int K_LOCK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] digit;
  logic       submit;
  logic       clear;
  logic       waiting;
  logic       correct;
  logic       incorrect;
  logic       locked;
  logic [2:0] digits_in;
  logic       bug;

  typedef struct {
    int kind;
    int appear;
    bit lockNext;
  } expItem_t;

  expItem_t expQ[$];
  int total = 0;
  int bad = 0;
  int cycleCnt = 0;

  pin_verifier #(
    .DIGIT_W     (2),
    .PIN_LEN     (4),
    .PASSKEY     (8'b10100101),
    .HOLD_CYCLES (HOLD),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (LOCKC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digit     (digit),
    .submit    (submit),
    .clear     (clear),
    .waiting   (waiting),
    .correct   (correct),
    .incorrect (incorrect),
    .locked    (locked),
    .digits_in (digits_in),
    .bug       (bug)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int want);
    total++;
    if (actual != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, want);
    end
  endtask

  // Monitor: pops an expectation on every result/lock rising edge, checks length on fall.
  bit       prevRes = 1'b0;
  bit       prevLock = 1'b0;
  int       resLen = 0;
  int       lockLen = 0;
  bit       curLockNext = 1'b0;
  expItem_t e;

  always @(negedge clk) begin
    if (reset) begin
      prevRes  = 1'b0;
      prevLock = 1'b0;
      resLen   = 0;
      lockLen  = 0;
    end else begin
      if ((correct || incorrect) && !prevRes) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected result", 1, 0);
          curLockNext = 1'b0;
        end else begin
          e = expQ.pop_front();
          checkOutput("result kind {correct,incorrect}", int'({correct, incorrect}),
                      (e.kind == K_OK) ? 2 : ((e.kind == K_BAD) ? 1 : 0));
          checkOutput("result latency", cycleCnt, e.appear);
          curLockNext = e.lockNext;
        end
        resLen = 1;
      end else if (correct || incorrect) begin
        resLen++;
      end else if (prevRes) begin
        checkOutput("result hold length", resLen, HOLD);
        checkOutput("waiting after hold", int'(waiting), curLockNext ? 0 : 1);
      end

      if (locked && !prevLock) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected lock", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("lock event kind", e.kind, K_LOCK);
          checkOutput("lock latency", cycleCnt, e.appear);
        end
        lockLen = 1;
      end else if (locked) begin
        lockLen++;
      end else if (prevLock) begin
        checkOutput("lock length", lockLen, LOCKC);
        checkOutput("waiting after lock", int'(waiting), 1);
      end

      prevRes  = correct || incorrect;
      prevLock = locked;
    end
  end

  // One digit per cycle, back to back; returns on the negedge after the last sampling edge.
  task automatic applyStimulus(input logic [7:0] pin);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      digit  = pin[7-2*i -: 2];
      submit = 1'b1;
    end
    @(negedge clk);
    submit = 1'b0;
  endtask

  task automatic singleDigit(input logic [1:0] d, input logic clr);
    @(negedge clk);
    digit  = d;
    submit = 1'b1;
    clear  = clr;
    @(negedge clk);
    submit = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic enterPin(input logic [7:0] pin, input int kind, input bit lockNext);
    int k;
    applyStimulus(pin);
    k = cycleCnt;
    expQ.push_back('{kind, k + 1, lockNext});
    if (lockNext) expQ.push_back('{K_LOCK, k + 1 + HOLD, 1'b0});
  endtask

  task automatic waitReady(input int maxCyc);
    int n = 0;
    while (!waiting && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waiting returns within budget", int'(waiting), 1);
  endtask

  initial begin
    reset  = 1'b1;
    digit  = 2'd0;
    submit = 1'b0;
    clear  = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("reset waiting", int'(waiting), 1);
    checkOutput("reset correct", int'(correct), 0);
    checkOutput("reset incorrect", int'(incorrect), 0);
    checkOutput("reset locked", int'(locked), 0);
    checkOutput("reset bug", int'(bug), 0);
    checkOutput("reset digits_in", int'(digits_in), 0);

    enterPin(GOOD_PIN, K_OK, 1'b0);
    waitReady(20);

    enterPin(ZERO_PIN, K_BAD, 1'b0);
    waitReady(20);

    singleDigit(2'd3, 1'b0);
    singleDigit(2'd3, 1'b0);
    checkOutput("digits_in after two digits", int'(digits_in), 2);
    singleDigit(2'd3, 1'b1);
    checkOutput("digits_in after clear", int'(digits_in), 0);
    checkOutput("waiting after clear", int'(waiting), 1);
    enterPin(GOOD_PIN, K_OK, 1'b0);
    waitReady(20);

`ifdef LOCKOUT_EN
    enterPin(ZERO_PIN, K_BAD, 1'b0);
    waitReady(20);
    enterPin(ZERO_PIN, K_BAD, 1'b0);
    waitReady(20);
    enterPin(ZERO_PIN, K_BAD, 1'b1);
    for (int n = 0; n < 20 && !locked; n++) @(negedge clk);
    checkOutput("locked asserted", int'(locked), 1);
    applyStimulus(GOOD_PIN);
    checkOutput("digits_in ignored during lock", int'(digits_in), 0);
    checkOutput("still locked after ignored pin", int'(locked), 1);
    checkOutput("waiting low during lock", int'(waiting), 0);
    waitReady(30);
    enterPin(GOOD_PIN, K_OK, 1'b0);
    waitReady(20);
`endif

    checkOutput("bug flag clear", int'(bug), 0);

    enterPin(GOOD_PIN, K_OK, 1'b0);
    for (int n = 0; n < 10 && !correct; n++) @(negedge clk);
    checkOutput("correct before async reset", int'(correct), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset drops correct", int'(correct), 0);
    checkOutput("async reset incorrect", int'(incorrect), 0);
    checkOutput("async reset waiting", int'(waiting), 1);
    checkOutput("async reset digits_in", int'(digits_in), 0);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    repeat (6) @(negedge clk);
    checkOutput("waiting after reset release", int'(waiting), 1);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
